// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared encodings for the SPI command/register-file stage
package spi_pkg;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_DROP = 2'd3
    } spi_state_t;

    localparam int RW_BIT     = 7;
    localparam int RSV_BIT    = 6;
    localparam int ADDR_LSB   = 0;
    localparam int ADDR_MSB   = 5;

    localparam int DONE_BYTE  = 0;
    localparam int DONE_FRAME = 1;

endpackage

// File: rtl/spi_regfile.sv
// rtl/spi_regfile.sv - byte register array with status byte mapped at the top address
module spi_regfile #(
    parameter int N_REGS = 16,
    parameter int ADDR_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [7:0]                wr_data,
    input  logic [ADDR_W-1:0]         rd_addr,
    input  logic [7:0]                status,
    output logic [7:0]                rd_data,
    output logic [8*(N_REGS-1)-1:0]   regs
);

    logic [7:0] mem [N_REGS-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_REGS-1; k++) mem[k] <= 8'h00;
        end else if (wr_en) begin
            for (int k = 0; k < N_REGS-1; k++)
                if (wr_addr == ADDR_W'(k)) mem[k] <= wr_data;
        end
    end

    // Any address not backed by mem (only N_REGS-1 once headers are validated) reads status.
    always_comb begin
        rd_data = status;
        for (int k = 0; k < N_REGS-1; k++)
            if (rd_addr == ADDR_W'(k)) rd_data = mem[k];
    end

    always_comb begin
        regs = '0;
        for (int k = 0; k < N_REGS-1; k++) regs[8*k +: 8] = mem[k];
    end

endmodule

// File: rtl/spi_cmd_regfile_module.sv
// rtl/spi_cmd_regfile_module.sv - header decode and burst read/write of the SPI register file
module spi_cmd_regfile_module
    import spi_pkg::*;
#(
    parameter int         N_REGS    = 16,
    parameter int         ADDR_W    = 4,
    parameter logic [7:0] IDLE_BYTE = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                iDone,
    input  logic [7:0]                iData,
    output logic                      oCall,
    output logic [7:0]                oData,
    input  logic [7:0]                iStatus,
    output logic [8*(N_REGS-1)-1:0]   oRegs,
    output logic                      oWrStb,
    output logic [ADDR_W-1:0]         oWrAddr,
    output logic [7:0]                oErrCnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_REGS-1);

    spi_state_t        state;
    logic [ADDR_W-1:0] addr;
    logic              byte_in, frame_end, hdr_bad, wr_en;
    logic [5:0]        hdr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;

    // Wrap at N_REGS rather than at 2**ADDR_W so non-power-of-2 files stay in range.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] n;
        n = {1'b0, a} + (ADDR_W+1)'(1);
        return (n >= (ADDR_W+1)'(N_REGS)) ? '0 : n[ADDR_W-1:0];
    endfunction

    always_comb begin
        byte_in   = iDone[DONE_BYTE];
        frame_end = iDone[DONE_FRAME];
        hdr_addr  = iData[ADDR_MSB:ADDR_LSB];
        hdr_bad   = iData[RSV_BIT] || ({1'b0, hdr_addr} >= 7'(N_REGS));
        rd_addr   = (state == ST_HDR) ? iData[ADDR_W-1:0] : addr;
        wr_en     = byte_in && (state == ST_WR) && (addr != LAST_ADDR);
    end

    spi_regfile #(.N_REGS(N_REGS), .ADDR_W(ADDR_W)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (addr),
        .wr_data (iData),
        .rd_addr (rd_addr),
        .status  (iStatus),
        .rd_data (rd_data),
        .regs    (oRegs)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_HDR;
            addr    <= '0;
            oCall   <= 1'b0;
            oData   <= IDLE_BYTE;
            oWrStb  <= 1'b0;
            oWrAddr <= '0;
            oErrCnt <= 8'h00;
        end else begin
            oCall  <= 1'b0;
            oWrStb <= 1'b0;
            if (byte_in) begin
                unique case (state)
                    ST_HDR: begin
                        if (hdr_bad) begin
                            state <= ST_DROP;
                            if (oErrCnt != 8'hFF) oErrCnt <= oErrCnt + 8'h01;
                        end else if (iData[RW_BIT]) begin
                            state <= ST_RD;
                            oCall <= 1'b1;
                            oData <= rd_data;
                            addr  <= addr_inc(iData[ADDR_W-1:0]);
                        end else begin
                            state <= ST_WR;
                            addr  <= iData[ADDR_W-1:0];
                        end
                    end
                    ST_WR: begin
                        if (wr_en) begin
                            oWrStb  <= 1'b1;
                            oWrAddr <= addr;
                        end
                        addr <= addr_inc(addr);
                    end
                    ST_RD: begin
                        oCall <= 1'b1;
                        oData <= rd_data;
                        addr  <= addr_inc(addr);
                    end
                    ST_DROP: ;
                endcase
            end
            // Frame end wins over any read preload issued by the same byte.
            if (frame_end) begin
                state <= ST_HDR;
                oCall <= 1'b1;
                oData <= IDLE_BYTE;
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_regfile_module.sv
// tb/tb_spi_cmd_regfile_module.sv - directed-vector bench for spi_cmd_regfile_module
module tb_spi_cmd_regfile_module;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   iDone;
    logic [7:0]   iData;
    logic         oCall;
    logic [7:0]   oData;
    logic [7:0]   iStatus;
    logic [119:0] oRegs;
    logic         oWrStb;
    logic [3:0]   oWrAddr;
    logic [7:0]   oErrCnt;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] callq[$];
    logic [3:0] wrq[$];
    logic [119:0] snap;

    spi_cmd_regfile_module #(.N_REGS(16), .ADDR_W(4), .IDLE_BYTE(8'h00)) dut (
        .clk     (clk),
        .rst     (rst),
        .iDone   (iDone),
        .iData   (iData),
        .oCall   (oCall),
        .oData   (oData),
        .iStatus (iStatus),
        .oRegs   (oRegs),
        .oWrStb  (oWrStb),
        .oWrAddr (oWrAddr),
        .oErrCnt (oErrCnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (oCall)  callq.push_back(oData);
            if (oWrStb) wrq.push_back(oWrAddr);
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse(input logic [7:0] d, input logic [1:0] done);
        @(negedge clk);
        iData = d;
        iDone = done;
        @(negedge clk);
        iDone = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] reg_of(input int k);
        return oRegs[8*k +: 8];
    endfunction

    function automatic logic [7:0] cq(input int i);
        return (i < callq.size()) ? callq[i] : 8'hxx;
    endfunction

    function automatic logic [3:0] wq(input int i);
        return (i < wrq.size()) ? wrq[i] : 4'hx;
    endfunction

    task automatic check_reset_state(input string pfx);
        chk({pfx, "_call"},  oCall,   1'b0);
        chk({pfx, "_data"},  oData,   8'h00);
        chk({pfx, "_regs"},  oRegs,   120'h0);
        chk({pfx, "_wrstb"}, oWrStb,  1'b0);
        chk({pfx, "_wradr"}, oWrAddr, 4'h0);
        chk({pfx, "_err"},   oErrCnt, 8'h00);
    endtask

    initial begin
        rst = 1'b1; iDone = 2'b00; iData = 8'h00; iStatus = 8'h5A;
        idle(2);
        check_reset_state("rst");
        rst = 1'b0;
        idle(1);

        // write burst 02: 11 22 33
        pulse(8'h02, 2'b01);
        pulse(8'h11, 2'b01);
        pulse(8'h22, 2'b01);
        pulse(8'h33, 2'b01);
        pulse(8'h00, 2'b10);
        chk("wr_end_call_lat", oCall, 1'b1);
        chk("wr_end_data",     oData, 8'h00);
        idle(2);
        chk("wr_reg2", reg_of(2), 8'h11);
        chk("wr_reg3", reg_of(3), 8'h22);
        chk("wr_reg4", reg_of(4), 8'h33);
        chk("wr_nstb", wrq.size(), 3);
        chk("wr_adr0", wq(0), 4'd2);
        chk("wr_adr1", wq(1), 4'd3);
        chk("wr_adr2", wq(2), 4'd4);
        chk("wr_ncall", callq.size(), 1);

        // preload 13,14, drop write at 15, wrap and write reg0
        pulse(8'h0D, 2'b01);
        pulse(8'hAB, 2'b01);
        pulse(8'hCD, 2'b01);
        pulse(8'hEE, 2'b01);
        pulse(8'h3C, 2'b01);
        pulse(8'h00, 2'b10);
        idle(2);
        chk("wrap_reg0", reg_of(0), 8'h3C);
        callq.delete(); wrq.delete();

        // read with wrap from 13
        pulse(8'h8D, 2'b01);
        pulse(8'h00, 2'b01);
        pulse(8'h00, 2'b01);
        pulse(8'h00, 2'b01);
        pulse(8'h00, 2'b10);
        idle(2);
        chk("rd_ncall", callq.size(), 5);
        chk("rd_d0", cq(0), 8'hAB);
        chk("rd_d1", cq(1), 8'hCD);
        chk("rd_d2", cq(2), 8'h5A);
        chk("rd_d3", cq(3), 8'h3C);
        chk("rd_d4", cq(4), 8'h00);
        callq.delete(); wrq.delete();

        // invalid headers
        snap = oRegs;
        pulse(8'h40, 2'b01);
        pulse(8'h12, 2'b01);
        pulse(8'h00, 2'b10);
        pulse(8'h15, 2'b01);
        pulse(8'h34, 2'b01);
        pulse(8'h00, 2'b10);
        idle(2);
        chk("bad_err2",  oErrCnt, 8'd2);
        chk("bad_nwr",   wrq.size(), 0);
        chk("bad_ncall", callq.size(), 2);
        chk("bad_c0",    cq(0), 8'h00);
        chk("bad_c1",    cq(1), 8'h00);
        chk("bad_regs",  oRegs, snap);
        for (int i = 0; i < 298; i++) pulse(8'h40, 2'b11);
        idle(2);
        chk("bad_sat", oErrCnt, 8'hFF);
        callq.delete(); wrq.delete();

        // write to status address is ignored, next byte wraps to reg0
        snap = oRegs;
        pulse(8'h0F, 2'b01);
        pulse(8'h77, 2'b01);
        idle(2);
        chk("st_nwr",  wrq.size(), 0);
        chk("st_regs", oRegs, snap);
        pulse(8'h5E, 2'b01);
        idle(2);
        chk("st_reg0", reg_of(0), 8'h5E);
        chk("st_adr",  wq(0), 4'd0);
        pulse(8'h00, 2'b10);
        idle(2);
        callq.delete(); wrq.delete();

        // byte and frame end together
        pulse(8'h05, 2'b01);
        pulse(8'h99, 2'b11);
        idle(2);
        chk("sim_reg5",  reg_of(5), 8'h99);
        chk("sim_ncall", callq.size(), 1);
        chk("sim_c0",    cq(0), 8'h00);
        pulse(8'h85, 2'b01);
        idle(2);
        chk("sim_hdr_rd", cq(1), 8'h99);
        pulse(8'h00, 2'b10);
        idle(2);

        // reset in the middle of a read frame
        pulse(8'h81, 2'b01);
        pulse(8'h00, 2'b01);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("mid");
        rst = 1'b0;
        callq.delete(); wrq.delete();
        pulse(8'h01, 2'b01);
        pulse(8'hC7, 2'b01);
        pulse(8'h00, 2'b10);
        pulse(8'h81, 2'b01);
        pulse(8'h00, 2'b10);
        idle(2);
        chk("post_reg1",  reg_of(1), 8'hC7);
        chk("post_adr",   wq(0), 4'd1);
        chk("post_ncall", callq.size(), 3);
        chk("post_rd",    cq(1), 8'hC7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_cmd_regfile_module.md
# spi_cmd_regfile_module

Command/register-file stage directly downstream of the SPI byte engine (`spi_func_module`). It consumes received bytes and their done strobes from the engine, decodes a one-byte command header, then streams writes into a local register file or streams register contents back. Readback uses the engine's oCall/oData preload handshake. The register file is exposed as a flat bus to fabric logic; the top register is a read-only status byte.

## Interface
- N_REGS, 16: register count including the status register; 2..64.
- ADDR_W, 4: address width; must equal clog2(N_REGS).
- IDLE_BYTE, 8'h00: byte preloaded for the header slot of every frame.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- iDone  in  2  from byte engine, one-cycle pulses:
  - [0] = byte received.
  - [1] = frame end (ncs rose).
  - Both may assert in the same cycle.
- iData  in  8  received byte; valid when iDone[0]=1.
- oCall  out  1  one-cycle pulse: engine loads oData as the next byte to shift out on miso.
- oData  out  8  preload byte; valid on the oCall cycle and held until the next oCall.
- iStatus  in  8  read-only value returned at address N_REGS-1; sampled when read.
- oRegs  out  8*(N_REGS-1)  writable registers 0..N_REGS-2, reg k at bits [8k+7:8k].
- oWrStb  out  1  one-cycle pulse per accepted register write.
- oWrAddr  out  ADDR_W  address of the write flagged by oWrStb.
- oErrCnt  out  8  saturating count of rejected command headers.

## Operation
- Header byte:
  - bit7 = 1 read, 0 write.
  - bit6 must be 0.
  - bits5:0 = start address.
  - Header is invalid if bit6=1 or address >= N_REGS.
- States:
  - HDR: awaiting header.
  - WR: each subsequent byte writes regs[addr], then addr increments.
  - RD: each subsequent byte is discarded as a dummy; addr increments.
  - DROP: invalid header; ignore bytes until frame end.
- Transitions on iDone[0] in HDR:
  - Valid write → WR.
  - Valid read → RD, with an immediate oCall of reg[addr] and addr++.
  - Invalid → DROP, oErrCnt++ (saturates at 8'hFF).
- In RD, each iDone[0] issues oCall with reg[addr] and addr++. The byte returned on miso therefore lags the header by one byte slot.
- Address wraps modulo N_REGS (N_REGS-1 → 0). Wrap is computed in ADDR_W+1 bits compared against N_REGS, not by power-of-2 truncation.
- Writes to address N_REGS-1 are ignored: no oWrStb, address still increments.
- Read of address N_REGS-1 returns iStatus sampled in the oCall cycle.
- iDone[1] from any state:
  - → HDR.
  - Issue oCall with oData=IDLE_BYTE so the next frame's header slot returns IDLE_BYTE.
- Simultaneous iDone[0] and iDone[1]:
  - The byte is fully processed first (write/count updated).
  - Any read-preload oCall is superseded by the frame-end oCall with IDLE_BYTE; only one pulse is issued.
  - State ends in HDR.
- Reset values:
  - state HDR, addr 0.
  - oCall 0, oData IDLE_BYTE.
  - oRegs all 0.
  - oWrStb 0, oWrAddr 0, oErrCnt 0.
- Reset mid-frame: all of the above apply immediately. The rest of the frame is parsed as if from HDR; the engine is expected to reset in step.

## Timing
- All outputs are registered.
- oCall, oWrStb and the oRegs update occur in cycle N+1 after the iDone pulse in cycle N. Latency is 1 clk.
- oData changes only in a cycle where oCall=1.
- Back-to-back iDone pulses on consecutive cycles are legal and must each be processed.
- The engine guarantees at least 8 sck periods between byte strobes; no buffering is required.

## Structure
- Shared package spi_pkg:
  - State encoding (HDR/WR/RD/DROP).
  - Header field positions (RW_BIT=7, RSV_BIT=6, ADDR_LSB=0, ADDR_MSB=5).
  - iDone bit indices (DONE_BYTE=0, DONE_FRAME=1).
- One natural sub-module, spi_regfile: register array, write port, combinational read mux with iStatus at the top address.
- The FSM and address counter stay in the parent.

## Test plan
- Write burst: header 8'h02, data 11,22,33, then frame end → regs2..4 = 11,22,33; three oWrStb with oWrAddr 2,3,4; oCall with 8'h00 one clk after frame end.
- Read with wrap (N_REGS=16, regs 13,14 = 8'hAB,8'hCD, iStatus=8'h5A): header 8'h8D then three dummy bytes → oData sequence AB, CD, 5A, then wraps to reg0.
- Invalid headers 8'h40 and 8'h15 in separate frames → no writes, no read oCall, oErrCnt=2. After 300 such frames, oErrCnt holds 8'hFF.
- Write to status address: header 8'h0F, data 8'h77 → no oWrStb, oRegs unchanged. A second data byte writes reg0.
- Simultaneous iDone=2'b11 on the last write byte of frame (header 8'h05, data 8'h99) → reg5=8'h99; exactly one oCall, with 8'h00; state HDR.
- Assert rst during RD after two bytes → all outputs at reset values on the next edge. A following 8'h81 frame reads from reg1.
